// File: rtl/prefetch_fetch_unit.sv
// prefetch_fetch_unit: PC generator, level-based imem request handshake and a
// QDEPTH-entry prefetch queue of {pc, instruction} pairs feeding decode.
// Redirects (absolute or PC-relative) flush the queue and restart fetching.
module prefetch_fetch_unit #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          imem_req,
  output logic [ADDR_W-1:0]             imem_addr,
  input  logic                          imem_ack,
  input  logic [DATA_W-1:0]             imem_rdata,
  input  logic                          redirect_valid,
  input  logic                          redirect_rel,
  input  logic [ADDR_W-1:0]             redirect_pc,
  input  logic [15:0]                   redirect_offset,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [DATA_W-1:0]             instr_data,
  output logic [ADDR_W-1:0]             instr_pc,
  output logic [$clog2(QDEPTH+1)-1:0]   q_count
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH+1);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_q_pc   [QDEPTH];
  logic [DATA_W-1:0] r_q_data [QDEPTH];

  logic              w_xfer;
  logic              w_deq;
  logic              w_enq;
  logic [ADDR_W-1:0] w_offset_ext;
  logic [ADDR_W-1:0] w_target_raw;
  logic [ADDR_W-1:0] w_target;

  // Request only while there is room; based purely on registered occupancy so a
  // same-cycle dequeue does not raise the request until the following cycle.
  assign imem_req  = (r_count < CNT_W'(QDEPTH));
  assign imem_addr = r_fetch_pc;

  assign w_xfer = imem_req && imem_ack;
  assign w_deq  = instr_valid && instr_ready;
  // A redirect or reset in the same cycle discards the returned word.
  assign w_enq  = w_xfer && !redirect_valid && !reset;

  // Word offset sign-extended and scaled to a byte offset.
  assign w_offset_ext = {{(ADDR_W-18){redirect_offset[15]}}, redirect_offset, 2'b00};
  assign w_target_raw = redirect_rel ? (redirect_pc + ADDR_W'(PC_STEP) + w_offset_ext)
                                     : redirect_pc;
  // Targets are always word aligned regardless of what the requester supplied.
  assign w_target     = {w_target_raw[ADDR_W-1:2], 2'b00};

  assign instr_valid = (r_count != '0);
  assign instr_data  = instr_valid ? r_q_data[r_head] : '0;
  assign instr_pc    = instr_valid ? r_q_pc[r_head]   : '0;
  assign q_count     = r_count;

  // Queue storage: write the fetched {pc, word} at the tail on an accepted transfer.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_pc[r_tail]   <= r_fetch_pc;
      r_q_data[r_tail] <= imem_rdata;
    end
  end

  // PC, pointers and occupancy: reset beats redirect beats normal transfer/dequeue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC[ADDR_W-1:0];
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_target;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      if (w_xfer) begin
        r_tail     <= r_tail + PTR_W'(1);
        r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
      end
      if (w_deq) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_xfer, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Self-checking bench for prefetch_fetch_unit: directed sequences, a redirect
// target table and randomized traffic against a queue-based reference model.
module tb_prefetch_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic        redirect_rel;
  logic [31:0] redirect_pc;
  logic [15:0] redirect_offset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [2:0]  q_count;

  logic [31:0] key = 32'hA5A5_0000;

  int checks   = 0;
  int failures = 0;

  prefetch_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_rel    (redirect_rel),
    .redirect_pc     (redirect_pc),
    .redirect_offset (redirect_offset),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .q_count         (q_count)
  );

  always #5 clk = ~clk;

  // Memory: returns a word derived from the requested address.
  assign imem_rdata = imem_addr ^ key;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_pc;

  function automatic logic [31:0] calc_target(logic rel, logic [31:0] base, logic [15:0] off);
    int          soff;
    logic [31:0] t;
    soff = int'($signed(off));
    if (rel) t = base + 32'd4 + 32'(soff * 4);
    else     t = base;
    return t & 32'hFFFF_FFFC;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_clock();
    bit     can_req;
    bit     has_head;
    entry_t e;
    can_req  = (mq.size() < 4);
    has_head = (mq.size() != 0);
    if (reset) begin
      mq.delete();
      m_pc = 32'h0;
    end else if (redirect_valid) begin
      mq.delete();
      m_pc = calc_target(redirect_rel, redirect_pc, redirect_offset);
    end else begin
      if (has_head && instr_ready) void'(mq.pop_front());
      if (can_req && imem_ack) begin
        e.pc   = m_pc;
        e.data = m_pc ^ key;
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic compare_all(string tag);
    logic [31:0] epc;
    logic [31:0] edata;
    epc   = (mq.size() != 0) ? mq[0].pc   : 32'h0;
    edata = (mq.size() != 0) ? mq[0].data : 32'h0;
    chk({tag, ".req"},   {31'h0, imem_req},    {31'h0, mq.size() < 4});
    chk({tag, ".addr"},  imem_addr,            m_pc);
    chk({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, mq.size() != 0});
    chk({tag, ".count"}, {29'h0, q_count},     32'(mq.size()));
    chk({tag, ".pc"},    instr_pc,             epc);
    chk({tag, ".data"},  instr_data,           edata);
  endtask

  // One clock: update the model with current inputs, clock the DUT, compare.
  task automatic step(string tag);
    model_clock();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    reset           = 1'b0;
    imem_ack        = 1'b0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_rel    = 1'b0;
    redirect_pc     = 32'h0;
    redirect_offset = 16'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step("reset");
    step("reset");
    reset = 1'b0;
  endtask

  // ---------------- redirect target table ----------------
  typedef struct {
    logic        rel;
    logic [31:0] base;
    logic [15:0] off;
    logic [31:0] exp_addr;
  } redir_vec_t;

  redir_vec_t rtab[7];

  initial begin
    idle_inputs();
    rtab[0] = '{1'b0, 32'h0000_1003, 16'h0000, 32'h0000_1000};
    rtab[1] = '{1'b1, 32'h0000_0100, 16'hFFFE, 32'h0000_00FC};
    rtab[2] = '{1'b1, 32'h0000_0100, 16'h0003, 32'h0000_0110};
    rtab[3] = '{1'b0, 32'hFFFF_FFFF, 16'h1234, 32'hFFFF_FFFC};
    rtab[4] = '{1'b1, 32'hFFFF_FFFC, 16'h0000, 32'h0000_0000};
    rtab[5] = '{1'b1, 32'h0000_0000, 16'h8000, 32'hFFFE_0004};
    rtab[6] = '{1'b1, 32'h0000_0002, 16'h0001, 32'h0000_0008};

    // Reset state
    do_reset();
    chk("rst.count", {29'h0, q_count}, 32'h0);
    chk("rst.valid", {31'h0, instr_valid}, 32'h0);
    chk("rst.data",  instr_data, 32'h0);
    chk("rst.pc",    instr_pc, 32'h0);
    chk("rst.addr",  imem_addr, 32'h0);
    $display("seq reset: checked reset state");

    // Streaming: one instruction per cycle, visible the cycle after transfer
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    step("s1");
    for (int k = 0; k < 8; k++) begin
      chk("s1.valid", {31'h0, instr_valid}, 32'h1);
      chk("s1.pc",    instr_pc, 32'(k * 4));
      chk("s1.data",  instr_data, 32'(k * 4) ^ 32'hA5A5_0000);
      step("s1");
    end
    $display("seq stream: 8 instructions at pc 0..0x1c");

    // Fill to QDEPTH with consumer stalled, then release one entry
    do_reset();
    imem_ack = 1'b1;
    for (int k = 0; k < 4; k++) step("s2");
    chk("s2.full_count", {29'h0, q_count}, 32'd4);
    chk("s2.full_req",   {31'h0, imem_req}, 32'h0);
    chk("s2.full_addr",  imem_addr, 32'h10);
    step("s2");
    chk("s2.hold_count", {29'h0, q_count}, 32'd4);
    instr_ready = 1'b1;
    step("s2");
    instr_ready = 1'b0;
    chk("s2.deq_count", {29'h0, q_count}, 32'd3);
    chk("s2.deq_req",   {31'h0, imem_req}, 32'h1);
    chk("s2.deq_addr",  imem_addr, 32'h10);
    step("s2");
    chk("s2.refill_count", {29'h0, q_count}, 32'd4);
    $display("seq fill: queue full at 4, reopened after one dequeue");

    // Redirect with 3 entries queued
    do_reset();
    imem_ack = 1'b1;
    for (int k = 0; k < 3; k++) step("s3");
    imem_ack       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1003;
    step("s3");
    redirect_valid = 1'b0;
    chk("s3.count", {29'h0, q_count}, 32'h0);
    chk("s3.valid", {31'h0, instr_valid}, 32'h0);
    chk("s3.addr",  imem_addr, 32'h0000_1000);
    $display("seq flush: redirect with 3 queued -> addr 0x1000");

    // Table of redirect targets
    for (int i = 0; i < 7; i++) begin
      imem_ack        = 1'b0;
      redirect_valid  = 1'b1;
      redirect_rel    = rtab[i].rel;
      redirect_pc     = rtab[i].base;
      redirect_offset = rtab[i].off;
      step("tab");
      redirect_valid = 1'b0;
      chk("tab.addr",  imem_addr, rtab[i].exp_addr);
      chk("tab.count", {29'h0, q_count}, 32'h0);
      $display("vec %0d: rel=%0d base=%h off=%h -> addr=%h", i, rtab[i].rel,
               rtab[i].base, rtab[i].off, imem_addr);
    end

    // Redirect coinciding with transfer and dequeue, then slow memory
    do_reset();
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) step("s5");
    redirect_valid = 1'b1;
    redirect_rel   = 1'b0;
    redirect_pc    = 32'h0000_2000;
    step("s5");
    redirect_valid = 1'b0;
    chk("s5.flush_count", {29'h0, q_count}, 32'h0);
    chk("s5.flush_valid", {31'h0, instr_valid}, 32'h0);
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step("s5");
      chk("s5.wait_addr",  imem_addr, 32'h0000_2000);
      chk("s5.wait_count", {29'h0, q_count}, 32'h0);
    end
    imem_ack = 1'b1;
    step("s5");
    imem_ack = 1'b0;
    chk("s5.one_count", {29'h0, q_count}, 32'd1);
    chk("s5.one_pc",    instr_pc, 32'h0000_2000);
    chk("s5.one_data",  instr_data, 32'h0000_2000 ^ 32'hA5A5_0000);
    chk("s5.next_addr", imem_addr, 32'h0000_2004);
    $display("seq redirect-collide: single enqueue at 0x2000");

    // Address wrap and reset overriding a redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step("s6");
    redirect_valid = 1'b0;
    imem_ack = 1'b1;
    step("s6");
    imem_ack = 1'b0;
    chk("s6.wrap_addr", imem_addr, 32'h0);
    chk("s6.wrap_pc",   instr_pc, 32'hFFFF_FFFC);
    imem_ack = 1'b1;
    step("s6");
    step("s6");
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3000;
    step("s6");
    reset          = 1'b0;
    redirect_valid = 1'b0;
    imem_ack       = 1'b0;
    chk("s6.rst_addr",  imem_addr, 32'h0);
    chk("s6.rst_count", {29'h0, q_count}, 32'h0);
    $display("seq wrap/reset: 0xFFFFFFFC wraps to 0, reset beats redirect");

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      imem_ack        = ($urandom_range(0, 99) < 60);
      instr_ready     = ($urandom_range(0, 99) < 55);
      redirect_valid  = ($urandom_range(0, 99) < 4);
      redirect_rel    = $urandom_range(0, 1) == 1;
      redirect_pc     = $urandom;
      redirect_offset = 16'($urandom);
      reset           = ($urandom_range(0, 299) == 0);
      step("rnd");
    end
    idle_inputs();
    $display("seq random: 1500 cycles compared against model");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
